// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared helpers and mode constants for the contador_multi counter bank
package contador_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A single-channel bank still needs a one-bit select field.
    function automatic int ch_width(input int num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

endpackage

// File: rtl/contador_canal.sv
// rtl/contador_canal.sv - one event counter with clear, wrap/saturate mode and sticky overflow
module contador_canal
    import contador_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SAT   = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            // A beat landing on the cleared cycle still counts.
            cnt <= inc ? CNT_W'(1) : '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                ovf <= 1'b1;
                cnt <= (SAT == MODE_SAT) ? cnt : '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/contador_multi.sv
// rtl/contador_multi.sv - multi-channel event counter bank with registered read port
module contador_multi
    import contador_pkg::*;
#(
    parameter int   DATA_W    = 12,
    parameter int   CNT_W     = 16,
    parameter int   NUM_CH    = 4,
    parameter int   CLASS_LSB = 8,
    parameter int   SAT       = MODE_WRAP,
    localparam int  CH_W      = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_req,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic              rd_clr,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic              drop,
    output logic [CNT_W-1:0]  cuenta_total
);

    logic [CH_W-1:0]  cls;
    logic             cls_ok;
    logic             accept;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] clr;
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [NUM_CH-1:0] ovf;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_ovf;
    logic             unused_beat;

    // Only the class field steers the bank; the rest of the beat is ignored.
    assign unused_beat = ^data_in;
    assign cls         = data_in[CLASS_LSB +: CH_W];
    assign cls_ok      = int'(cls) < NUM_CH;
    assign accept      = valid && cls_ok;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_canal
        assign inc[g] = accept && (cls == CH_W'(g));
        assign clr[g] = rd_req && rd_clr && (rd_ch == CH_W'(g));

        contador_canal #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_canal (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[g]),
            .clr   (clr[g]),
            .cnt   (cnt[g]),
            .ovf   (ovf[g])
        );
    end

    // Out-of-range channels fall through to the zero default.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                sel_cnt = cnt[i];
                sel_ovf = ovf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_ovf       <= 1'b0;
            drop         <= 1'b0;
            cuenta_total <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= sel_cnt;
                rd_ovf  <= sel_ovf;
            end
            drop <= valid && !cls_ok;
            if (accept) begin
                if (&cuenta_total) begin
                    cuenta_total <= (SAT == MODE_SAT) ? cuenta_total : '0;
                end else begin
                    cuenta_total <= cuenta_total + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_contador_multi.sv
// tb/tb_contador_multi.sv - randomized and directed bench for contador_multi against a behavioural model
module tb_contador_multi;

    localparam int DW   = 12;
    localparam int CW   = 4;
    localparam int NCH  = 3;
    localparam int CLSB = 8;
    localparam int CHW  = 2;
    localparam int MAXV = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           valid = 1'b0;
    logic [DW-1:0]  data_in = '0;
    logic           rd_req = 1'b0;
    logic [CHW-1:0] rd_ch = '0;
    logic           rd_clr = 1'b0;

    logic           rv_w, ro_w, dr_w, rv_s, ro_s, dr_s;
    logic [CW-1:0]  rd_w, tot_w, rd_s, tot_s;

    int n_pass = 0;
    int n_chk  = 0;

    int m_cnt [2][NCH];
    bit m_ovf [2][NCH];
    int m_tot [2];
    int e_rd  [2];
    bit e_ro  [2];
    bit e_rv;
    bit e_drop;

    always #5 clk = ~clk;

    contador_multi #(.DATA_W(DW), .CNT_W(CW), .NUM_CH(NCH), .CLASS_LSB(CLSB), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .valid(valid), .data_in(data_in), .rd_req(rd_req),
        .rd_ch(rd_ch), .rd_clr(rd_clr), .rd_valid(rv_w), .rd_data(rd_w), .rd_ovf(ro_w),
        .drop(dr_w), .cuenta_total(tot_w)
    );

    contador_multi #(.DATA_W(DW), .CNT_W(CW), .NUM_CH(NCH), .CLASS_LSB(CLSB), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .valid(valid), .data_in(data_in), .rd_req(rd_req),
        .rd_ch(rd_ch), .rd_clr(rd_clr), .rd_valid(rv_s), .rd_data(rd_s), .rd_ovf(ro_s),
        .drop(dr_s), .cuenta_total(tot_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[s][c] = 0;
                m_ovf[s][c] = 0;
            end
            m_tot[s] = 0;
            e_rd[s]  = 0;
            e_ro[s]  = 0;
        end
        e_rv   = 0;
        e_drop = 0;
    endtask

    function automatic int bump(input int v, input int sat, output bit of);
        if (v == MAXV) begin
            of = 1;
            return sat ? MAXV : 0;
        end
        of = 0;
        return v + 1;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".wrap.rd_valid"}, 32'(rv_w), 32'(e_rv));
        check({tag, ".wrap.rd_data"}, 32'(rd_w), e_rd[0]);
        check({tag, ".wrap.rd_ovf"}, 32'(ro_w), 32'(e_ro[0]));
        check({tag, ".wrap.drop"}, 32'(dr_w), 32'(e_drop));
        check({tag, ".wrap.total"}, 32'(tot_w), m_tot[0]);
        check({tag, ".sat.rd_valid"}, 32'(rv_s), 32'(e_rv));
        check({tag, ".sat.rd_data"}, 32'(rd_s), e_rd[1]);
        check({tag, ".sat.rd_ovf"}, 32'(ro_s), 32'(e_ro[1]));
        check({tag, ".sat.drop"}, 32'(dr_s), 32'(e_drop));
        check({tag, ".sat.total"}, 32'(tot_s), m_tot[1]);
    endtask

    // One clock: drive, predict from the pre-edge model state, advance, compare.
    task automatic cycle(input string tag, input bit v, input int cls, input bit rq,
                         input int ch, input bit clr);
        logic [DW-1:0] d;
        bit of;
        d = DW'($urandom);
        d[CLSB +: CHW] = CHW'(cls);
        valid   = v;
        data_in = d;
        rd_req  = rq;
        rd_ch   = CHW'(ch);
        rd_clr  = clr;
        e_rv   = rq;
        e_drop = v && (cls >= NCH);
        for (int s = 0; s < 2; s++) begin
            if (rq) begin
                e_rd[s] = (ch < NCH) ? m_cnt[s][ch] : 0;
                e_ro[s] = (ch < NCH) ? m_ovf[s][ch] : 0;
            end
            if (rq && clr && ch < NCH) begin
                m_cnt[s][ch] = 0;
                m_ovf[s][ch] = 0;
            end
            if (v && cls < NCH) begin
                m_cnt[s][cls] = bump(m_cnt[s][cls], s, of);
                if (of) m_ovf[s][cls] = 1;
                m_tot[s] = bump(m_tot[s], s, of);
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset_init");
        @(posedge clk);
        #1;
        reset = 1'b1;

        cycle("rd0_after_reset", 0, 0, 1, 0, 0);

        for (int i = 0; i < 5; i++) cycle("beat_c2", 1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("beat_c0", 1, 0, 0, 0, 0);
        cycle("rd_c2", 0, 0, 1, 2, 0);
        cycle("idle_hold", 0, 0, 0, 0, 0);

        for (int i = 0; i < 17; i++) cycle("beat_c1x17", 1, 1, 0, 0, 0);
        cycle("rd_c1_ovf", 0, 0, 1, 1, 0);

        cycle("beat_c2", 1, 2, 0, 0, 0);
        cycle("beat_c2", 1, 2, 0, 0, 0);
        cycle("clr_collide", 1, 2, 1, 2, 1);
        cycle("rd_after_collide", 0, 0, 1, 2, 0);

        cycle("clr_c1", 0, 0, 1, 1, 1);
        cycle("rd_c1_cleared", 0, 0, 1, 1, 0);

        cycle("illegal_beat", 1, 3, 0, 0, 0);
        cycle("after_drop", 0, 0, 0, 0, 0);
        cycle("rd_illegal_ch", 0, 0, 1, 3, 1);

        for (int c = 0; c < 4; c++) cycle("b2b_read", 0, 0, 1, c, 0);
        cycle("b2b_tail", 0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            cycle("random", $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        // Pull reset between edges while a read is pending.
        valid  = 1'b1;
        rd_req = 1'b1;
        rd_ch  = 2'd0;
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        valid  = 1'b0;
        rd_req = 1'b0;
        reset  = 1'b1;
        cycle("rd0_after_rerelease", 0, 0, 1, 0, 0);
        cycle("final_idle", 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/contador_multi.md
# contador_multi

Parametrised multi-channel event counter for the PCIe transaction-layer counter suite; generalises the single 16-bit counter to NUM_CH independent channels. A class field in `data_in` selects which channel a valid beat increments. Software-style reads use a one-cycle request/response handshake with optional clear-on-read. Per-channel sticky overflow flags and a selectable wrap/saturate mode are provided. The block sits beside the transaction-layer datapath as its statistics bank.

## Interface
- `DATA_W`, 12, width of `data_in`
- `CNT_W`, 16, width of each channel counter and of `cuenta_total`
- `NUM_CH`, 4, number of channels (1..16, need not be a power of two)
- `CLASS_LSB`, 8, LSB of the class field `data_in[CLASS_LSB +: CH_W]`, where CH_W = max(1, clog2(NUM_CH))
- `SAT`, 0, 0 = wrap at 2^CNT_W, 1 = saturate at 2^CNT_W−1

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `valid`  in  1  `data_in` carries a beat to be counted this cycle
- `data_in`  in  DATA_W  beat; only the class field is used
- `rd_req`  in  1  read request, one per cycle allowed
- `rd_ch`  in  CH_W  channel to read
- `rd_clr`  in  1  clear the read channel (counter and overflow flag) with this read
- `rd_valid`  out  1  response strobe
- `rd_data`  out  CNT_W  counter value of requested channel
- `rd_ovf`  out  1  sticky overflow flag of requested channel
- `drop`  out  1  registered pulse: valid beat had class ≥ NUM_CH and was discarded
- `cuenta_total`  out  CNT_W  count of all accepted beats, same SAT/wrap rule, not cleared by reads

## Operation
- Reset (reset=0): all channel counters, overflow flags, `cuenta_total`, `rd_valid`, `rd_data`, `rd_ovf`, `drop` = 0.
- Accept: valid=1 and class < NUM_CH → channel[class] += 1, `cuenta_total` += 1.
- Drop: valid=1 and class ≥ NUM_CH → no counter changes; `drop`=1 next cycle.
- Overflow: increment at 2^CNT_W−1 sets that channel's sticky flag; SAT=0 → counter becomes 0; SAT=1 → stays at max. `cuenta_total` follows the same rule and has no flag.
- Read: rd_req=1 samples channel rd_ch; the response carries the value and flag **before** this cycle's update.
- rd_ch ≥ NUM_CH: response has `rd_valid`=1, `rd_data`=0, `rd_ovf`=0; `rd_clr` is ignored.
- Clear-on-read: rd_req=1 and rd_clr=1 → counter and flag set to 0 at the end of the cycle.
- Same-cycle clear and increment on the same channel: counter becomes 1 and the flag becomes 0. The increment is never lost; the read returns the pre-clear value.
- The bank is stateless beyond the counters; there is no FSM beyond the read response register.

## Timing
- Counter update latency: 1 cycle (value visible in a read issued the next cycle).
- `rd_valid`, `rd_data`, `rd_ovf`: registered, asserted exactly 1 cycle after `rd_req`; `rd_valid` is held 1 for back-to-back requests, else 0. `rd_data`/`rd_ovf` hold their last value when `rd_valid`=0.
- `drop`: 1-cycle pulse, 1 cycle after the offending beat.
- reset asserted mid-read: the pending response is discarded (`rd_valid`=0). First count after reset release occurs on the first rising edge with reset=1.

## Structure
- Shared package `contador_pkg`: `clog2` function, SAT/wrap mode constants, the CH_W derivation.
- Sub-module `contador_canal`: one CNT_W counter with inc, clr, SAT mode, and sticky overflow; instantiated NUM_CH times via generate. The top level holds class decode, the read mux/response register, `cuenta_total`, and `drop`.

## Test plan
- Reset: drive beats, pull reset low asynchronously between edges → all outputs 0 immediately; a read of ch0 after release returns 0.
- Defaults: 5 beats class 2, 3 beats class 0, then read ch2 → `rd_valid` 1 cycle later with `rd_data`=5, `rd_ovf`=0; `cuenta_total`=8.
- Wrap vs saturate, CNT_W=4: 17 beats on ch1 → SAT=0 gives `rd_data`=1 with `rd_ovf`=1; SAT=1 gives 15 with `rd_ovf`=1.
- Clear collision: ch3=7; in the same cycle issue valid class 3 and rd_req ch3 with rd_clr → response 7; next read returns 1 with `rd_ovf`=0.
- Illegal class, NUM_CH=3: beat with class 3 → `drop` pulse, counters and `cuenta_total` unchanged; read rd_ch=3 → `rd_valid`=1, `rd_data`=0.
- Back-to-back reads of ch0..ch3 on 4 consecutive cycles → 4 consecutive `rd_valid` cycles with matching values, each lagging its request by 1 cycle.
